// File: rtl/ms_mul_arbiter_if.sv
// Bundle of request, response and multiplier-side signals for ms_mul_arbiter.
// master = arbiter view, slave = requesters / consumer / multiplier view.
interface ms_mul_arbiter_if #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int NUM_REQ    = 4,
  parameter int RES_W      = 16
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int OP_W = NUM_INPUTS * DATA_WIDTH;

  // Handshake rule for both channels: a transfer happens on a rising clk edge
  // where valid and ready are both 1; valid never waits on ready.
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*OP_W-1:0]    req_data;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic [RES_W-1:0]           resp_data;
  logic                       resp_err;
  logic                       busy;
  logic                       mul_rst;
  logic                       mul_en;
  logic [OP_W-1:0]            mul_data_in;
  logic [WXIP1-1:0]           mul_data_out;
  logic                       mul_done;

  modport master (
    input  req_valid, req_data, resp_ready, mul_data_out, mul_done,
    output req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
           mul_rst, mul_en, mul_data_in
  );

  modport slave (
    output req_valid, req_data, resp_ready, mul_data_out, mul_done,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
           mul_rst, mul_en, mul_data_in
  );
endinterface

// File: rtl/ms_mul_arbiter.sv
// Round-robin scheduler sharing one MS-first serial multiplier among NUM_REQ requesters.
// Define MS_MUL_ARB_PERF_EN to add the perf_ops / perf_busy saturating counters.
module ms_mul_arbiter #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int NUM_REQ    = 4,
  parameter int RES_W      = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             rst,
  ms_mul_arbiter_if.master bus,
`ifdef MS_MUL_ARB_PERF_EN
  output logic [15:0]      perf_ops,
  output logic [31:0]      perf_busy,
`endif
  output logic [1:0]       dbg_state_o
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int OP_W  = NUM_INPUTS * DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  // Holds grants off until the first clock after reset release, so req_ready
  // is 0 throughout reset regardless of req_valid.
  logic               arm_q;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               mul_rst_c, mul_en_c, resp_valid_c;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_d         = op_q;
    id_d         = id_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    req_ready_c  = '0;
    mul_rst_c    = 1'b0;
    mul_en_c     = 1'b0;
    resp_valid_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found && arm_q) begin
          req_ready_c[gnt_idx] = 1'b1;
          op_d     = bus.req_data[int'(gnt_idx)*OP_W +: OP_W];
          id_d     = gnt_idx;
          rr_ptr_d = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mul_rst_c = 1'b1;
        res_d     = '0;
        cnt_d     = '0;
        err_d     = 1'b0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        mul_en_c = 1'b1;
        res_d    = {res_q[RES_W-WXIP1-1:0], bus.mul_data_out};
        cnt_d    = cnt_q + 1'b1;
        // A done on the last allowed cycle still counts as a clean finish.
        if (bus.mul_done) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      op_q     <= '0;
      id_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      id_q     <= id_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      arm_q    <= 1'b1;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.resp_valid  = resp_valid_c;
  assign bus.resp_id     = id_q;
  assign bus.resp_data   = res_q;
  assign bus.resp_err    = err_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.mul_rst     = mul_rst_c;
  assign bus.mul_en      = mul_en_c;
  assign bus.mul_data_in = op_q;
  assign dbg_state_o     = state_q;

`ifdef MS_MUL_ARB_PERF_EN
  logic [15:0] perf_ops_q;
  logic [31:0] perf_busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      if (state_q == ST_RESP && bus.resp_ready && perf_ops_q != '1)
        perf_ops_q <= perf_ops_q + 1'b1;
      if (state_q != ST_IDLE && perf_busy_q != '1)
        perf_busy_q <= perf_busy_q + 1'b1;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`endif
endmodule

// File: tb/tb_ms_mul_arbiter.sv
// Directed bench for ms_mul_arbiter with a small serial-multiplier stand-in.
// Digits come from dig_pat[k], k = mul_en cycles since the last mul_rst.
module tb_ms_mul_arbiter;
  localparam int DW  = 5;
  localparam int NI  = 2;
  localparam int WX  = 1;
  localparam int NR  = 4;
  localparam int RW  = 16;
  localparam int TO  = 32;
  localparam int OPW = DW * NI;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ms_mul_arbiter_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX),
                      .NUM_REQ(NR), .RES_W(RW)) bus ();
  logic [1:0] dbg_state;
`ifdef MS_MUL_ARB_PERF_EN
  logic [15:0] perf_ops;
  logic [31:0] perf_busy;
`endif

  ms_mul_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX),
                   .NUM_REQ(NR), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef MS_MUL_ARB_PERF_EN
    .perf_ops    (perf_ops),
    .perf_busy   (perf_busy),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- multiplier stand-in ----------------
  logic [63:0] dig_pat;
  int          done_at;
  int          k;

  always @(posedge clk or negedge rst) begin
    if (!rst)             k <= 0;
    else if (bus.mul_rst) k <= 0;
    else if (bus.mul_en)  k <= k + 1;
  end
  assign bus.mul_data_out = dig_pat[k];
  assign bus.mul_done     = bus.mul_en && (done_at != 0) && (k == done_at - 1);

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_data[idx*OPW +: OPW] = {b, a};
  endtask

  task automatic wait_resp(input string tag);
    int g;
    g = 0;
    while (!bus.resp_valid && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!bus.resp_valid) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic count_en_until_resp(output int en_cnt);
    int g;
    en_cnt = 0;
    g = 0;
    while (!bus.resp_valid && g < 100) begin
      if (bus.mul_en) en_cnt++;
      @(negedge clk);
      #1;
      g++;
    end
    if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         en_cnt;
    int         g;
    logic [3:0] onehot;
    logic [1:0] exp_id;

    bus.req_valid  = 4'hF;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    dig_pat        = '0;
    done_at        = 0;

    // Reset: everything quiet even with all requests raised.
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_mul_en", 32'(bus.mul_en), 32'h0);
    chk("rst_mul_rst", 32'(bus.mul_rst), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_resp_data", 32'(bus.resp_data), 32'h0);
    chk("rst_mul_data_in", 32'(bus.mul_data_in), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    bus.req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'h0);

    // Single request: digits 1,0,1,1, done on the 4th digit.
    dig_pat = 64'hD;
    done_at = 4;
    set_req(2, 5'd12, 5'd6);
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_c0_req_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_c1_mul_rst", 32'(bus.mul_rst), 32'h1);
    chk("t1_c1_mul_en", 32'(bus.mul_en), 32'h0);
    chk("t1_mul_data_in", 32'(bus.mul_data_in), 32'h0CC);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk); #1;
      chk("t1_run_mul_en", 32'(bus.mul_en), 32'h1);
    end
    @(negedge clk); #1;
    chk("t1_c6_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("t1_resp_data", 32'(bus.resp_data), 32'h000B);
    chk("t1_resp_id", 32'(bus.resp_id), 32'h2);
    chk("t1_resp_err", 32'(bus.resp_err), 32'h0);
    chk("t1_resp_mul_en", 32'(bus.mul_en), 32'h0);
    consume();
    chk("t1_idle_busy", 32'(bus.busy), 32'h0);

    // Timeout: never done, all-ones digits; rr_ptr=3 wraps the search to 0.
    dig_pat = '1;
    done_at = 0;
    set_req(0, 5'd3, 5'd7);
    bus.req_valid = 4'b0001;
    #1;
    chk("to_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    count_en_until_resp(en_cnt);
    chk("to_en_cycles", 32'(en_cnt), 32'd32);
    chk("to_resp_err", 32'(bus.resp_err), 32'h1);
    chk("to_resp_data", 32'(bus.resp_data), 32'hFFFF);
    consume();

    // Done on the 32nd RUN cycle: not an error; only the last 16 digits survive.
    dig_pat = 64'h0000_0000_F000_FFFF;
    done_at = 32;
    bus.req_valid = 4'b0001;
    #1;
    chk("sim_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    count_en_until_resp(en_cnt);
    chk("sim_en_cycles", 32'(en_cnt), 32'd32);
    chk("sim_resp_err", 32'(bus.resp_err), 32'h0);
    chk("sim_resp_data", 32'(bus.resp_data), 32'h000F);
    consume();

    // Backpressure: response held for 10 cycles while requester 1 waits.
    dig_pat = 64'h3;
    done_at = 2;
    set_req(3, 5'd1, 5'd2);
    bus.req_valid = 4'b1000;
    #1;
    chk("bp_req_ready3", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    wait_resp("bp_resp_timeout");
    set_req(1, 5'd3, 5'd4);
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
      chk("bp_resp_data", 32'(bus.resp_data), 32'h3);
      chk("bp_resp_id", 32'(bus.resp_id), 32'h3);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
      chk("bp_mul_data_in", 32'(bus.mul_data_in), 32'h041);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_rise_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("bp_grant1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    wait_resp("bp2_resp_timeout");
    chk("bp2_resp_id", 32'(bus.resp_id), 32'h1);
    chk("bp2_mul_data_in", 32'(bus.mul_data_in), 32'h083);
    consume();

    // Reset on the 2nd RUN cycle; rr_ptr is 2 here.
    dig_pat = 64'hF;
    done_at = 0;
    bus.req_valid = 4'b0100;
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk); #1;
    chk("mr_run2_mul_en", 32'(bus.mul_en), 32'h1);
    rst = 1'b0;
    #1;
    chk("mr_async_mul_en", 32'(bus.mul_en), 32'h0);
    chk("mr_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("mr_busy", 32'(bus.busy), 32'h0);
    bus.req_valid = 4'hF;
    #1;
    chk("mr_rst_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_rel_resp_valid", 32'(bus.resp_valid), 32'h0);
    @(negedge clk); #1;

    // Round robin from a fresh pointer: 0,1,2,3,0, responses in the same order.
    dig_pat = 64'h1;
    done_at = 1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_id = 2'(i % NR);
      g = 0;
      while (bus.req_ready == '0 && g < 20) begin
        @(negedge clk); #1;
        g++;
      end
      onehot = 4'b0001 << exp_id;
      chk("rr_grant", 32'(bus.req_ready), 32'(onehot));
      exp_q.push_back(exp_id);
      @(negedge clk); #1;
      wait_resp("rr_resp_timeout");
      if (exp_q.size() != 0) chk("rr_resp_id", 32'(bus.resp_id), 32'(exp_q.pop_front()));
      chk("rr_resp_data", 32'(bus.resp_data), 32'h1);
    end
    bus.req_valid  = 4'h0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("end_busy", 32'(bus.busy), 32'h0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ms_mul_arbiter.md
Name: ms_mul_arbiter

Overview:
- Round-robin scheduler that shares one ms_serial_by2_mul instance among NUM_REQ requesters.
- Accepts operand sets via valid/ready and sequences the multiplier: clear, enable, collect the MS-first serial output digits until done.
- Returns the assembled result with the requester ID over a valid/ready response channel.
- Sits between the requesting cores and the multiplier in the arch_sweep datapath.

Parameters:
- DATA_WIDTH, 5, width of each operand; matches the multiplier.
- NUM_INPUTS, 2, operands per request; matches the multiplier.
- WXIP1, 1, width of the multiplier output digit per cycle.
- NUM_REQ, 4, number of requesters; must be ≥2.
- RES_W, 16, width of the result shift register; a multiple of WXIP1.
- TIMEOUT, 32, maximum RUN cycles before an abort.
- ID_W, $clog2(NUM_REQ), requester ID width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*NUM_INPUTS*DATA_WIDTH  operands; requester i occupies slice i.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  RES_W  collected result digits, most recent digit in the LSBs.
- resp_err  out  1  result aborted by timeout.
- busy  out  1  high in any state other than IDLE.
- mul_rst  out  1  active-high clear pulse to the multiplier.
- mul_en  out  1  multiplier enable.
- mul_data_in  out  NUM_INPUTS*DATA_WIDTH  latched operands to the multiplier.
- mul_data_out  in  WXIP1  serial output digit from the multiplier.
- mul_done  in  1  multiplier completion flag.

Behaviour:
- Reset values, while rst=0 and on exit from reset:
  - All outputs 0, including req_ready=0.
  - State IDLE, rr_ptr=0, result register 0, cycle counter 0.
- Reset asserted mid-operation aborts immediately:
  - No response is produced.
  - mul_en drops asynchronously to 0.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Grant g = the first index with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; every other req_ready bit is 0.
  - On the handshake: latch req_data slice g into the operand register, latch g into the ID register, set rr_ptr<=(g+1)%NUM_REQ, go to LOAD.
  - No req_valid set: remain in IDLE; rr_ptr unchanged.
- LOAD, exactly 1 cycle:
  - mul_rst=1, mul_en=0.
  - Clear the result register and the cycle counter.
  - Go to RUN.
- RUN:
  - mul_en=1.
  - Every cycle: result <= {result[RES_W-WXIP1-1:0], mul_data_out}, and counter++.
  - mul_done=1: the digit sampled in that same cycle is included; go to RESP with err=0.
  - Counter reaches TIMEOUT-1 without mul_done: go to RESP with err=1.
  - mul_done and timeout in the same cycle: mul_done wins, err=0.
- RESP:
  - resp_valid=1 with resp_data, resp_id and resp_err held stable.
  - mul_en=0.
  - On resp_ready=1, go to IDLE.
  - resp_ready held low: remain in RESP indefinitely, with no new grant.
- mul_data_in:
  - Driven from the operand register at all times.
  - Stable from LOAD through RESP.
  - Updates only on a grant.
- Latency:
  - Grant to the first mul_en cycle: 2 cycles.
  - mul_done to resp_valid: 1 cycle.
  - Minimum spacing between grants: 3 cycles plus the RUN length.
- Result register overflow: digits older than RES_W/WXIP1 shift out and are lost; there is no error for this.
- A requester that drops req_valid before being granted is simply skipped.
- Fairness: a requester that holds req_valid continuously is granted within NUM_REQ operations.

Optional Feature:
- Macro: MS_MUL_ARB_PERF_EN.
- Defined: adds two outputs.
  - perf_ops [15:0]: increments on each RESP→IDLE handshake.
  - perf_busy [31:0]: increments every cycle that busy=1.
  - Both reset to 0 and saturate at all-ones.
- Undefined: these ports and counters do not exist.
- Core behaviour is identical either way.

Test Plan:
- Single request. Multiplier model emits digits 1,0,1,1 with mul_done on the 4th digit; req_valid[2]=1 with operands 5'd12, 5'd6. Required:
  - req_ready[2] is high in cycle 0.
  - mul_rst is high in cycle 1.
  - mul_en is high in cycles 2–5.
  - resp_valid is high in cycle 6 with resp_data=16'h000B, resp_id=2, resp_err=0.
- Round-robin. All four req_valid held high and resp_ready=1. Required:
  - Grant order is 0,1,2,3,0.
  - resp_id follows the same sequence.
- Timeout. The model never asserts mul_done. Required:
  - Exactly 32 mul_en cycles.
  - Then resp_valid=1 with resp_err=1.
- Simultaneous timeout and done. mul_done asserts on the 32nd RUN cycle. Required: resp_err=0.
- Backpressure. Hold resp_ready=0 for 10 cycles while req_valid[1]=1. Required:
  - resp_valid, resp_data and resp_id stay stable throughout.
  - req_ready stays 0 throughout.
  - Grant to requester 1 occurs one cycle after resp_ready rises.
- Reset mid-RUN. Drive rst=0 on the 2nd RUN cycle, then release. Required:
  - mul_en drops immediately.
  - No resp_valid is produced.
  - The next grant, with all four req_valid high, goes to index 0.
